// File: rtl/display_pkg.sv
// display_pkg: shared FSM state, segment patterns and BCD helpers for display_driver
package display_pkg;
  localparam int BIN_W = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
  function automatic logic [3:0] adj3(input logic [3:0] d);
    return d >= 4'd5 ? d + 4'd3 : d;
  endfunction
endpackage

// File: rtl/display_driver_bcd_converter.sv
// bcd_converter: iterative double-dabble binary->BCD with a one-deep newest-wins pending load.
// DISPLAY_SIGNED_EN: input is two's complement; magnitude is converted and the sign reported on o_neg.
module bcd_converter
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic [BIN_W-1:0] i_value,
  input  logic             i_load,
  output logic [3:0]       o_hund,
  output logic [3:0]       o_tens,
  output logic [3:0]       o_ones,
`ifdef DISPLAY_SIGNED_EN
  output logic             o_neg,
`endif
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_done
);
  state_t             r_state, w_next;
  logic [BIN_W+11:0]  r_sh, w_shifted;
  logic [11:0]        w_adj;
  logic [2:0]         r_cnt;
  logic               r_pend, w_start;
  logic [BIN_W-1:0]   r_pend_val, w_raw, w_mag;
  logic [3:0]         r_hund, r_tens, r_ones;
  logic               r_valid, r_done;
  // A load arriving in COMMIT wins over the older pending value
  assign w_raw = i_load ? i_value : r_pend_val;
`ifdef DISPLAY_SIGNED_EN
  assign w_mag = w_raw[BIN_W-1] ? ~w_raw + 1'b1 : w_raw;
`else
  assign w_mag = w_raw;
`endif
  assign w_adj     = {adj3(r_sh[BIN_W+11:BIN_W+8]), adj3(r_sh[BIN_W+7:BIN_W+4]), adj3(r_sh[BIN_W+3:BIN_W])};
  assign w_shifted = {w_adj, r_sh[BIN_W-1:0]} << 1;
  always_comb begin
    w_next  = r_state == IDLE  ? (i_load ? SHIFT : IDLE) :
              r_state == SHIFT ? (r_cnt == 3'd7 ? COMMIT : SHIFT) :
              (i_load || r_pend) ? SHIFT : IDLE;
    w_start = (r_state == IDLE && i_load) || (r_state == COMMIT && (i_load || r_pend));
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= IDLE;
      r_sh       <= '0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_hund     <= '0;
      r_tens     <= '0;
      r_ones     <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= r_state == COMMIT;
      if (w_start) begin
        r_sh  <= {12'd0, w_mag};
        r_cnt <= '0;
      end else if (r_state == SHIFT) begin
        r_sh  <= w_shifted;
        r_cnt <= r_cnt + 3'd1;
      end
      if (r_state == COMMIT) begin
        r_hund  <= r_sh[BIN_W+11:BIN_W+8];
        r_tens  <= r_sh[BIN_W+7:BIN_W+4];
        r_ones  <= r_sh[BIN_W+3:BIN_W];
        r_valid <= 1'b1;
        r_pend  <= 1'b0;
      end else if (r_state == SHIFT && i_load) begin
        r_pend     <= 1'b1;
        r_pend_val <= i_value;
      end
    end
  end
`ifdef DISPLAY_SIGNED_EN
  logic r_neg_sh, r_neg;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_neg_sh <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      if (w_start) r_neg_sh <= w_raw[BIN_W-1];
      if (r_state == COMMIT) r_neg <= r_neg_sh;
    end
  end
  assign o_neg = r_neg;
`endif
  assign o_hund  = r_hund;
  assign o_tens  = r_tens;
  assign o_ones  = r_ones;
  assign o_valid = r_valid;
  assign o_busy  = r_state == SHIFT;
  assign o_done  = r_done;
endmodule

// File: rtl/display_driver.sv
// display_driver: latches an 8-bit value, converts it to BCD and scans it onto a 4-digit 7-segment display.
// DISPLAY_SIGNED_EN: treat value as two's complement and show a minus sign on the leftmost digit.
module display_driver
  import display_pkg::*;
#(
  parameter int SCAN_DIV       = 1024,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [BIN_W-1:0] value,
  input  logic             load,
  output logic [6:0]       seg,
  output logic [3:0]       dig_en,
  output logic             busy,
  output logic             done
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [3:0]    w_hund, w_tens, w_ones, w_onehot, w_dig;
  logic          w_valid, w_neg;
  logic [6:0]    w_seg, w_seg3;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;
  logic [6:0]    r_seg;
  logic [3:0]    r_dig;
  bcd_converter u_conv (
    .clk     (clk),
    .clr     (clr),
    .i_value (value),
    .i_load  (load),
    .o_hund  (w_hund),
    .o_tens  (w_tens),
    .o_ones  (w_ones),
`ifdef DISPLAY_SIGNED_EN
    .o_neg   (w_neg),
`endif
    .o_valid (w_valid),
    .o_busy  (busy),
    .o_done  (done)
  );
`ifndef DISPLAY_SIGNED_EN
  assign w_neg = 1'b0;
`endif
  // Leading-zero blanking; blank digits keep their enable so every slot lasts SCAN_DIV cycles
  always_comb begin
    w_seg3   = w_neg ? SEG_MINUS : SEG_BLANK;
    w_seg    = !w_valid     ? SEG_BLANK :
               r_idx == 2'd0 ? seg_of(w_ones) :
               r_idx == 2'd1 ? ((w_hund == 4'd0 && w_tens == 4'd0) ? SEG_BLANK : seg_of(w_tens)) :
               r_idx == 2'd2 ? (w_hund == 4'd0 ? SEG_BLANK : seg_of(w_hund)) : w_seg3;
    w_onehot = w_valid ? 4'(4'b0001 << r_idx) : 4'b0000;
    w_dig    = DIG_ACTIVE_LOW ? ~w_onehot : w_onehot;
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pre <= '0;
      r_idx <= '0;
      r_seg <= SEG_BLANK;
      r_dig <= DIG_ACTIVE_LOW ? 4'hF : 4'h0;
    end else begin
      r_pre <= r_pre == PW'(SCAN_DIV - 1) ? '0 : r_pre + PW'(1);
      if (r_pre == PW'(SCAN_DIV - 1)) r_idx <= r_idx + 2'd1;
      r_seg <= w_seg;
      r_dig <= w_dig;
    end
  end
  assign seg    = r_seg;
  assign dig_en = r_dig;
endmodule

// File: tb/tb_display_driver.sv
// tb_display_driver: randomized and directed stimulus checked against a decimal/scan-schedule reference model.
module tb_display_driver;
  localparam int SD = 8;
  logic       clk, clr, load;
  logic [7:0] value;
  logic [6:0] seg;
  logic [3:0] dig_en;
  logic       busy, done;
  int checks, errors, k, commit_at, cur, pend, disp, dones;
  bit pend_v, valid;
  logic [6:0] enc [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                           7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  display_driver #(.SCAN_DIV(SD), .DIG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .clr(clr), .value(value), .load(load),
    .seg(seg), .dig_en(dig_en), .busy(busy), .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (edge %0d)", tag, got, exp, k);
    end
  endtask
  function automatic logic [6:0] exp_seg(input int i, input int v, input bit vld);
    int m, h, t, o;
    bit n;
`ifdef DISPLAY_SIGNED_EN
    m = v >= 128 ? 256 - v : v;
    n = v >= 128;
`else
    m = v;
    n = 1'b0;
`endif
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    if (!vld) return 7'd0;
    case (i)
      0:       return enc[o];
      1:       return (h == 0 && t == 0) ? 7'd0 : enc[t];
      2:       return h == 0 ? 7'd0 : enc[h];
      default: return n ? 7'b1000000 : 7'd0;
    endcase
  endfunction
  function automatic logic [3:0] exp_dig(input int i, input bit vld);
    return vld ? ~(4'b0001 << i) : 4'hF;
  endfunction
  task automatic mreset();
    k = 0; commit_at = -1; pend_v = 0; valid = 0; disp = 0; cur = 0; pend = 0;
  endtask
  task automatic step(input bit ld, input logic [7:0] v);
    int i;
    logic [6:0] es;
    logic [3:0] ed;
    bit edone, ebusy;
    load = ld; value = v;
    @(posedge clk);
    k++;
    i  = ((k - 1) / SD) % 4;
    es = exp_seg(i, disp, valid);
    ed = exp_dig(i, valid);
    edone = commit_at == k;
    if (edone) begin
      disp = cur; valid = 1;
      if (ld) begin cur = v; commit_at = k + 9; pend_v = 0; end
      else if (pend_v) begin cur = pend; commit_at = k + 9; pend_v = 0; end
      else commit_at = -1;
    end else if (ld) begin
      if (commit_at < 0) begin cur = v; commit_at = k + 9; end
      else begin pend = v; pend_v = 1; end
    end
    ebusy = commit_at >= 0 && k >= commit_at - 9 && k <= commit_at - 2;
    @(negedge clk);
    load = 1'b0;
    check("seg", seg, es);
    check("dig_en", dig_en, ed);
    check("busy", busy, ebusy);
    check("done", done, edone);
    if (done) dones++;
  endtask
  initial begin
    checks = 0; errors = 0; dones = 0;
    clr = 1'b0; load = 1'b0; value = 8'd0;
    mreset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_seg", seg, 7'd0);
    check("rst_dig", dig_en, 4'hF);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    clr = 1'b1;
    repeat (4 * SD) step(1'b0, 8'd0);
    step(1'b1, 8'd0);
    repeat (40) step(1'b0, 8'd0);
    step(1'b1, 8'd255);
    repeat (40) step(1'b0, 8'd0);
    step(1'b1, 8'd7);
    repeat (40) step(1'b0, 8'd0);
    dones = 0;
    step(1'b1, 8'd100);
    step(1'b0, 8'd0);
    step(1'b1, 8'd42);
    step(1'b1, 8'd9);
    repeat (36) step(1'b0, 8'd0);
    check("pend_dones", dones, 2);
    step(1'b1, 8'd33);
    repeat (8) step(1'b0, 8'd0);
    step(1'b1, 8'd200);
    repeat (40) step(1'b0, 8'd0);
    step(1'b1, 8'hFF);
    repeat (40) step(1'b0, 8'd0);
    step(1'b1, 8'h80);
    repeat (40) step(1'b0, 8'd0);
    step(1'b1, 8'h7F);
    repeat (40) step(1'b0, 8'd0);
    repeat (600) step($urandom_range(0, 11) == 0, 8'($urandom));
    repeat (12) step(1'b0, 8'd0);
    step(1'b1, 8'd123);
    repeat (3) step(1'b0, 8'd0);
    #2 clr = 1'b0;
    #1;
    check("clr_seg", seg, 7'd0);
    check("clr_dig", dig_en, 4'hF);
    check("clr_busy", busy, 1'b0);
    check("clr_done", done, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    mreset();
    dones = 0;
    repeat (40) step(1'b0, 8'd0);
    check("clr_no_done", dones, 0);
    repeat (200) step($urandom_range(0, 5) == 0, 8'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
